// File: rtl/accum_rr_scheduler_if.sv
// Sample-input and result-output bundle for accum_rr_scheduler.
// The master drives samples and accepts results; the slave is the scheduler itself.
interface accum_rr_scheduler_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 16
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_last;
  logic [NCH-1:0]    in_ready;
  logic              res_valid;
  logic              res_ready;
  logic [CW-1:0]     res_ch;
  logic [AW-1:0]     res_sum;
  logic              res_sat;
  logic              busy;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_ch, res_sum, res_sat, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_ch, res_sum, res_sat, busy
  );
endinterface

// File: rtl/accum_rr_scheduler.sv
// Round-robin shared saturating accumulator: one sample per cycle into per-channel sums,
// burst totals handed off through a single-entry valid/ready result register.
module accum_rr_scheduler #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 16
) (
  input logic                 clk,
  input logic                 rst,
  accum_rr_scheduler_if.slave bus
);
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW:0] NchW = (CW + 1)'(NCH);

  typedef enum logic [0:0] {StEmpty, StFull} res_state_e;

  res_state_e     state_q, state_d;
  logic           res_valid;

  logic [CW-1:0]  ptr_q, ptr_d;
  logic [AW-1:0]  acc_q [NCH];
  logic [NCH-1:0] sat_q;
  logic [CW-1:0]  res_ch_q;
  logic [AW-1:0]  res_sum_q;
  logic           res_sat_q;

  logic           out_free;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  grant_idx;
  logic [CW:0]    arb_pos;
  logic           arb_found;
  logic           accept;
  logic           last_accept;
  logic [DW-1:0]  sample;
  logic [AW:0]    sum_ext;
  logic           ovf;
  logic [AW-1:0]  sum_sat;
  logic           acc_nonzero;

  // A last sample may only go when the result slot is empty or draining this cycle.
  assign out_free = ~res_valid | bus.res_ready;
  assign eligible = bus.in_valid & (~bus.in_last | {NCH{out_free}});

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    arb_found = 1'b0;
    arb_pos   = '0;
    for (int k = 0; k < NCH; k++) begin
      arb_pos = {1'b0, ptr_q} + (CW + 1)'(k);
      if (arb_pos >= NchW) arb_pos = arb_pos - NchW;
      if (!arb_found && eligible[arb_pos[CW-1:0]]) begin
        arb_found                 = 1'b1;
        grant[arb_pos[CW-1:0]]    = 1'b1;
        grant_idx                 = arb_pos[CW-1:0];
      end
    end
    if (rst) grant = '0;
  end

  assign accept      = |grant;
  assign last_accept = accept & bus.in_last[grant_idx];
  assign sample      = bus.in_data[int'(grant_idx) * DW +: DW];
  assign sum_ext     = {1'b0, acc_q[grant_idx]} + {{(AW + 1 - DW){1'b0}}, sample};
  assign ovf         = sum_ext[AW];
  assign sum_sat     = ovf ? {AW{1'b1}} : sum_ext[AW-1:0];
  assign ptr_d       = !accept ? ptr_q :
                       (grant_idx == CW'(NCH - 1)) ? '0 : CW'(grant_idx + 1'b1);

  // Result register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (last_accept) state_d = StFull;
      StFull:  if (bus.res_ready && !last_accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    res_valid = (state_q == StFull);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      sat_q     <= '0;
      res_ch_q  <= '0;
      res_sum_q <= '0;
      res_sat_q <= 1'b0;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (last_accept) begin
        acc_q[grant_idx] <= '0;
        sat_q[grant_idx] <= 1'b0;
        res_ch_q         <= grant_idx;
        res_sum_q        <= sum_sat;
        res_sat_q        <= sat_q[grant_idx] | ovf;
      end else if (accept) begin
        acc_q[grant_idx] <= sum_sat;
        sat_q[grant_idx] <= sat_q[grant_idx] | ovf;
      end
    end
  end

  always_comb begin
    acc_nonzero = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (acc_q[i] != '0) acc_nonzero = 1'b1;
    end
  end

  assign bus.in_ready  = grant;
  assign bus.res_valid = res_valid;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.busy      = acc_nonzero | (|sat_q) | res_valid;
endmodule

// File: tb/tb_accum_rr_scheduler.sv
// Bench for accum_rr_scheduler: vector table plus hand sequences, with a reference
// model feeding a result scoreboard that is drained on every result handshake.
module tb_accum_rr_scheduler;
  logic clk;
  logic rst;

  accum_rr_scheduler_if #(.NCH(4), .DW(8), .AW(16)) bus ();

  accum_rr_scheduler #(.NCH(4), .DW(8), .AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated at each falling edge for the upcoming rising edge.
  typedef struct {int ch; int sum; bit sat;} res_t;
  res_t       sb[$];
  res_t       r_new, r_got;
  int         m_acc [4];
  bit         m_sat [4];
  int         m_ptr;
  bit         m_rv;
  int         g, idx, d, s, v;
  bit         ovf, out_free, next_rv, exp_busy;
  logic [3:0] exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_acc[i] = 0;
        m_sat[i] = 1'b0;
      end
      m_ptr = 0;
      m_rv  = 1'b0;
      sb.delete();
    end else begin
      out_free = !m_rv || bus.res_ready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && bus.in_valid[idx] && (!bus.in_last[idx] || out_free)) g = idx;
      end
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("model_in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("model_res_valid", 32'(bus.res_valid), 32'(m_rv));
      exp_busy = m_rv;
      for (int i = 0; i < 4; i++) if (m_acc[i] != 0 || m_sat[i]) exp_busy = 1'b1;
      chk("model_busy", 32'(bus.busy), 32'(exp_busy));
      if (m_rv && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 32'(sb.size()), 1);
        end else begin
          r_got = sb.pop_front();
          chk("sb_res_ch", 32'(bus.res_ch), r_got.ch);
          chk("sb_res_sum", 32'(bus.res_sum), r_got.sum);
          chk("sb_res_sat", 32'(bus.res_sat), 32'(r_got.sat));
        end
      end
      next_rv = m_rv && !bus.res_ready;
      if (g >= 0) begin
        d   = int'(bus.in_data[g*8 +: 8]);
        s   = m_acc[g] + d;
        ovf = (s > 65535);
        v   = ovf ? 65535 : s;
        if (bus.in_last[g]) begin
          r_new.ch  = g;
          r_new.sum = v;
          r_new.sat = m_sat[g] | ovf;
          sb.push_back(r_new);
          next_rv  = 1'b1;
          m_acc[g] = 0;
          m_sat[g] = 1'b0;
        end else begin
          m_acc[g] = v;
          m_sat[g] = m_sat[g] | ovf;
        end
        m_ptr = (g + 1) % 4;
      end
      m_rv = next_rv;
    end
  end

  task automatic drive(input logic [3:0] vl, input logic [31:0] dt, input logic [3:0] ls,
                       input logic rr);
    bus.in_valid  = vl;
    bus.in_data   = dt;
    bus.in_last   = ls;
    bus.res_ready = rr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  last;
    logic        rr;
    logic [3:0]  exp_rdy;
  } vec_t;
  vec_t tbl [11];

  initial begin
    // Round-robin from reset pointer, then each channel closes its burst in turn.
    for (int i = 0; i < 6; i++) tbl[i] = '{4'b1111, 32'h04030201, 4'b0000, 1'b1, 4'b0000};
    tbl[0].exp_rdy = 4'b0001;
    tbl[1].exp_rdy = 4'b0010;
    tbl[2].exp_rdy = 4'b0100;
    tbl[3].exp_rdy = 4'b1000;
    tbl[4].exp_rdy = 4'b0001;
    tbl[5].exp_rdy = 4'b0010;
    tbl[6]  = '{4'b1111, 32'h05050505, 4'b1111, 1'b1, 4'b0100};
    tbl[7]  = '{4'b1111, 32'h05050505, 4'b1111, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1111, 32'h05050505, 4'b1111, 1'b1, 4'b0001};
    tbl[9]  = '{4'b1111, 32'h05050505, 4'b1111, 1'b1, 4'b0010};
    tbl[10] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000};

    rst = 1'b1;
    drive(4'b0000, 32'h0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_ch", 32'(bus.res_ch), 0);
    chk("rst_res_sum", 32'(bus.res_sum), 0);
    chk("rst_res_sat", 32'(bus.res_sat), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].last, tbl[i].rr);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
      next_cycle();
    end

    // ch0 burst 10,20,30
    drive(4'b0001, 32'd10, 4'b0000, 1'b1);
    next_cycle();
    drive(4'b0001, 32'd20, 4'b0000, 1'b1);
    next_cycle();
    drive(4'b0001, 32'd30, 4'b0001, 1'b1);
    next_cycle();
    drive(4'b0000, 32'd0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t2_res_valid", 32'(bus.res_valid), 1);
    chk("t2_res_ch", 32'(bus.res_ch), 0);
    chk("t2_res_sum", 32'(bus.res_sum), 60);
    chk("t2_res_sat", 32'(bus.res_sat), 0);
    next_cycle();
    @(negedge clk);
    chk("t2_res_valid_drop", 32'(bus.res_valid), 0);
    next_cycle();

    // ch1 saturating burst, then a fresh unsaturated one
    repeat (300) begin
      drive(4'b0010, 32'h0000FF00, 4'b0000, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk("t3_busy", 32'(bus.busy), 1);
    drive(4'b0010, 32'h00000500, 4'b0010, 1'b1);
    next_cycle();
    drive(4'b0010, 32'h00000700, 4'b0010, 1'b1);
    @(negedge clk);
    chk("t3_in_ready", 32'(bus.in_ready), 'b0010);
    chk("t3_res_ch", 32'(bus.res_ch), 1);
    chk("t3_res_sum_sat", 32'(bus.res_sum), 'hFFFF);
    chk("t3_res_sat", 32'(bus.res_sat), 1);
    next_cycle();
    drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t3_res_sum_7", 32'(bus.res_sum), 7);
    chk("t3_res_sat_clr", 32'(bus.res_sat), 0);
    next_cycle();

    // Stalled result: ch2 last masked, ch3 non-last keeps flowing
    drive(4'b0001, 32'd42, 4'b0001, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1100, 32'h0B090000, 4'b0100, 1'b0);
      @(negedge clk);
      chk("t5_in_ready_ch3", 32'(bus.in_ready), 'b1000);
      chk("t5_hold_valid", 32'(bus.res_valid), 1);
      chk("t5_hold_ch", 32'(bus.res_ch), 0);
      chk("t5_hold_sum", 32'(bus.res_sum), 42);
      next_cycle();
    end
    drive(4'b1100, 32'h0B090000, 4'b0100, 1'b1);
    @(negedge clk);
    chk("t5_in_ready_ch2", 32'(bus.in_ready), 'b0100);
    next_cycle();
    drive(4'b1000, 32'h01000000, 4'b1000, 1'b1);
    @(negedge clk);
    chk("t5_res_ch2", 32'(bus.res_ch), 2);
    chk("t5_res_sum2", 32'(bus.res_sum), 9);
    next_cycle();
    drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t5_res_ch3", 32'(bus.res_ch), 3);
    chk("t5_res_sum3", 32'(bus.res_sum), 34);
    next_cycle();

    // ch0/ch2 interleaved bursts
    for (int i = 0; i < 4; i++) begin
      drive(4'b0101, 32'h00320003, 4'b0000, 1'b1);
      @(negedge clk);
      chk("t6_alternate", 32'(bus.in_ready), (i % 2 == 0) ? 'b0001 : 'b0100);
      next_cycle();
    end
    drive(4'b0101, 32'h00060004, 4'b0101, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("t6_res_ch0", 32'(bus.res_ch), 0);
    chk("t6_res_sum0", 32'(bus.res_sum), 10);
    next_cycle();
    drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t6_res_ch2", 32'(bus.res_ch), 2);
    chk("t6_res_sum2", 32'(bus.res_sum), 106);
    chk("t6_res_sat2", 32'(bus.res_sat), 0);
    next_cycle();

    // Reset with a held result and a partial ch1 burst
    drive(4'b0001, 32'd5, 4'b0001, 1'b0);
    next_cycle();
    drive(4'b0010, 32'h00006400, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("t1_busy_pre", 32'(bus.busy), 1);
    next_cycle();
    rst = 1'b1;
    drive(4'b0000, 32'h0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("t1_in_ready", 32'(bus.in_ready), 0);
    chk("t1_res_valid", 32'(bus.res_valid), 0);
    chk("t1_res_ch", 32'(bus.res_ch), 0);
    chk("t1_res_sum", 32'(bus.res_sum), 0);
    chk("t1_res_sat", 32'(bus.res_sat), 0);
    chk("t1_busy", 32'(bus.busy), 0);
    next_cycle();
    rst = 1'b0;
    drive(4'b1010, 32'h08000700, 4'b1010, 1'b1);
    @(negedge clk);
    chk("t1_ptr_zero", 32'(bus.in_ready), 'b0010);
    next_cycle();
    drive(4'b1000, 32'h08000700, 4'b1000, 1'b1);
    @(negedge clk);
    chk("t1_res_ch1", 32'(bus.res_ch), 1);
    chk("t1_res_sum1", 32'(bus.res_sum), 7);
    next_cycle();
    drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t1_res_ch3", 32'(bus.res_ch), 3);
    chk("t1_res_sum3", 32'(bus.res_sum), 8);
    next_cycle();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
